// File: rtl/md_unit_p.sv
// md_unit_p: parametrised multiply/divide unit with HI/LO registers.
// Each result is computed combinationally from operands latched at issue.
// A down-counter holds busy for the op's latency, and the result is
// committed on the edge where busy falls.
module md_unit_p #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] LAST_CNT = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Arithmetic results derived from the latched operands
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic                 is_signed, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Product and quotient/remainder from the latched operands. Signed
    // division works on magnitudes and restores the signs afterwards. The
    // overflow case -2^(W-1) / -1 needs no special handling: the magnitude
    // quotient 2^(W-1) negates back to itself, and the remainder is 0.
    always_comb begin
        is_signed = ~op_q[0];
        a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod      = a_ext * b_ext;

        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag     = a_neg ? -a_q : a_q;
        b_mag     = b_neg ? -b_q : b_q;
        div_zero  = (b_q == '0);
        q_mag     = '0;
        r_mag     = '0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem = a_neg ? -r_mag : r_mag;
    end

    // Next-state logic: idle accepts moves to HI/LO and issues; run counts down and commits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                // Moves land first so a same-cycle madd/msub snapshot sees them
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = {hi_d, lo_d};
                    cnt_d   = (op[2:1] == 2'b01) ? DIV_CNT : MULT_CNT;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    case (op_q[2:1])
                        2'b00: {hi_d, lo_d} = prod;
                        2'b01: if (!div_zero) {hi_d, lo_d} = {rem, quo};
                        2'b10: {hi_d, lo_d} = acc_q + prod;
                        default: {hi_d, lo_d} = acc_q - prod;
                    endcase
                end else begin
                    cnt_d = cnt_q - LAST_CNT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_md_unit_p.sv
// Testbench for md_unit_p: a 32-bit/5/10 instance and a 16-bit/1/3 instance
// driven from shared stimulus. Expected results are queued at issue, and per-
// instance monitors check them when busy falls.
module tb_md_unit_p;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_all = 1'b0, rst = 1'b0, st = 1'b0, whi = 1'b0, wlo = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  op_r = 3'd0;
    logic [31:0] a_r = '0, b_r = '0, wdata = '0;
    logic [31:0] msk, min_v;

    logic        reset32, start32, wr_hi32, wr_lo32, busy32;
    logic        reset16, start16, wr_hi16, wr_lo16, busy16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    int   checks = 0;
    int   fails  = 0;
    exp_t q32[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    assign reset32 = rst_all | (rst & ~sel);
    assign reset16 = rst_all | (rst & sel);
    assign start32 = st & ~sel;
    assign start16 = st & sel;
    assign wr_hi32 = whi & ~sel;
    assign wr_hi16 = whi & sel;
    assign wr_lo32 = wlo & ~sel;
    assign wr_lo16 = wlo & sel;

    md_unit_p #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut32 (
        .clk(clk), .reset(reset32), .start(start32), .op(op_r),
        .a(a_r), .b(b_r), .wr_hi(wr_hi32), .wr_lo(wr_lo32), .wdata(wdata),
        .hi(hi32), .lo(lo32), .busy(busy32)
    );

    md_unit_p #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .op(op_r),
        .a(a_r[15:0]), .b(b_r[15:0]), .wr_hi(wr_hi16), .wr_lo(wr_lo16), .wdata(wdata[15:0]),
        .hi(hi16), .lo(lo16), .busy(busy16)
    );

    function automatic logic cur_busy();
        return sel ? busy16 : busy32;
    endfunction
    function automatic logic [31:0] cur_hi();
        return sel ? {16'h0, hi16} : hi32;
    endfunction
    function automatic logic [31:0] cur_lo();
        return sel ? {16'h0, lo16} : lo32;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && cur_busy(); i++) tick();
        if (cur_busy()) begin
            checks++;
            fails++;
            $display("FAIL timeout: busy still 1, expected 0 within 100 cycles (w%0d)", sel ? 16 : 32);
        end
    endtask

    task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input int lat);
        exp_t e;
        e.hi = h & msk; e.lo = l & msk; e.lat = lat;
        if (sel) q16.push_back(e);
        else     q32.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input int lat);
        expect_res(h, l, lat);
        op_r = o; a_r = a & msk; b_r = b & msk; st = 1'b1;
        tick();
        st = 1'b0;
        wait_idle();
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        whi = h; wlo = l; wdata = d & msk;
        tick();
        whi = 1'b0; wlo = 1'b0;
        if (h) chk("mthi", cur_hi(), d & msk);
        if (l) chk("mtlo", cur_lo(), d & msk);
    endtask

    // One pass of the directed cases on the instance chosen by sel
    task automatic run_suite();
        int lm, ld;
        msk   = sel ? 32'h0000FFFF : 32'hFFFFFFFF;
        min_v = sel ? 32'h00008000 : 32'h80000000;
        lm    = sel ? 1 : 5;
        ld    = sel ? 3 : 10;

        issue(3'b000, 32'hFFFFFFFF, 32'd2, msk, msk - 1, lm);             // mult -1*2
        issue(3'b001, 32'hFFFFFFFF, 32'd2, 32'd1, msk - 1, lm);           // multu
        issue(3'b000, min_v, min_v, min_v >> 1, 32'd0, lm);               // mult min*min
        issue(3'b010, 32'hFFFFFFF9, 32'd2, msk, msk - 2, ld);             // div -7/2
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        issue(3'b011, 32'd5, 32'd0, 32'h11, 32'h22, ld);                  // divu by zero
        issue(3'b010, min_v, 32'hFFFFFFFF, 32'd0, min_v, ld);             // signed overflow
        mt(1'b1, 1'b1, 32'h5A);                                           // both at once
        mt(1'b1, 1'b0, 32'h0);
        mt(1'b0, 1'b1, 32'hFFFFFFFF);

        // madd 1*1 with a same-cycle mtlo 5: snapshot {0,5}
        expect_res(32'd0, 32'd6, lm);
        op_r = 3'b100; a_r = 32'd1; b_r = 32'd1; st = 1'b1; wlo = 1'b1; wdata = 32'd5;
        tick();
        st = 1'b0; wlo = 1'b0;
        wait_idle();
        issue(3'b111, 32'd3, 32'd3, msk, msk - 2, lm);                    // msubu: 6-9

        // mult 3*4 with mtlo 0xAA and a div start poked while busy
        expect_res(32'd0, 32'd12, lm);
        op_r = 3'b000; a_r = 32'd3; b_r = 32'd4; st = 1'b1;
        tick();
        st = 1'b0;
        if (!sel) tick();
        st = 1'b1; op_r = 3'b010; wlo = 1'b1; wdata = 32'hAA;
        tick();
        st = 1'b0; wlo = 1'b0;
        wait_idle();
        tick();
        chk("busy after ignored start", {31'd0, cur_busy()}, 32'd0);

        // Reset on cycle 3 of a div: result discarded
        expect_res(32'd0, 32'd0, 3);
        op_r = 3'b010; a_r = 32'd100; b_r = 32'd7; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("busy after mid-run reset", {31'd0, cur_busy()}, 32'd0);
        repeat (15) tick();
        chk("hi no late commit", cur_hi(), 32'd0);
        chk("lo no late commit", cur_lo(), 32'd0);

        // Reset together with start: reset wins
        mt(1'b0, 1'b1, 32'h33);
        op_r = 3'b000; a_r = 32'd3; b_r = 32'd4; st = 1'b1; rst = 1'b1;
        tick();
        st = 1'b0; rst = 1'b0;
        chk("busy reset+start", {31'd0, cur_busy()}, 32'd0);
        chk("lo reset+start", cur_lo(), 32'd0);
        tick();
        chk("busy reset+start later", {31'd0, cur_busy()}, 32'd0);
    endtask

    // Completion monitor for the 32-bit instance
    initial begin
        logic prev = 1'b0;
        int   cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy32) cnt++;
            if (prev && !busy32) begin
                if (q32.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL w32 completion: got unexpected completion, expected none queued");
                end else begin
                    e = q32.pop_front();
                    chk("w32 busy cycles", cnt, e.lat);
                    chk("w32 hi", hi32, e.hi);
                    chk("w32 lo", lo32, e.lo);
                end
                cnt = 0;
            end
            prev = busy32;
        end
    end

    // Completion monitor for the 16-bit instance
    initial begin
        logic prev = 1'b0;
        int   cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy16) cnt++;
            if (prev && !busy16) begin
                if (q16.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL w16 completion: got unexpected completion, expected none queued");
                end else begin
                    e = q16.pop_front();
                    chk("w16 busy cycles", cnt, e.lat);
                    chk("w16 hi", {16'h0, hi16}, e.hi);
                    chk("w16 lo", {16'h0, lo16}, e.lo);
                end
                cnt = 0;
            end
            prev = busy16;
        end
    end

    // Driver
    initial begin
        msk   = 32'hFFFFFFFF;
        min_v = 32'h80000000;
        rst_all = 1'b1;
        tick();
        tick();
        rst_all = 1'b0;
        chk("reset hi32", hi32, 32'd0);
        chk("reset lo32", lo32, 32'd0);
        chk("reset busy32", {31'd0, busy32}, 32'd0);
        chk("reset hi16", {16'h0, hi16}, 32'd0);
        chk("reset lo16", {16'h0, lo16}, 32'd0);
        chk("reset busy16", {31'd0, busy16}, 32'd0);

        sel = 1'b0;
        run_suite();
        sel = 1'b1;
        run_suite();

        repeat (3) tick();
        chk("w32 queue drained", q32.size(), 32'd0);
        chk("w16 queue drained", q16.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
